// File: rtl/icache_inv_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : icache_inv_scheduler
// Description : Queues per-line icache invalidations raised by stores to
//               instruction memory and runs full-cache flush sweeps on
//               fence.i. Invalidations are presented to the tag banks only
//               when the fetch path is not using them.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_inv_scheduler #(
  parameter int DEPTH      = 4,
  parameter int LINES      = 512,
  parameter int SUB_LINE_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inv_push,
  input  logic [29:0] inv_push_addr,
  output logic        inv_full,
  input  logic        flush_req,
  input  logic        fetch_busy,
  output logic        tag_inv_valid,
  output logic [29:0] tag_inv_addr,
  input  logic        tag_inv_ack,
  output logic        flush_busy,
  output logic        flush_done,
  output logic        queue_empty
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LINE_W = $clog2(LINES);
  localparam int TAG_W  = 30 - SUB_LINE_W;
  localparam int PAD_W  = 30 - LINE_W - SUB_LINE_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [TAG_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr, r_flush_wptr;
  logic [CNT_W-1:0]  r_count, r_sub_cnt, w_count_nxt;
  logic [LINE_W-1:0] r_sweep, w_sweep_nxt, w_sweep_inc;
  logic [29:0]       r_addr, w_addr_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_pending, w_pending_nxt;
  logic              r_done, w_done_nxt;
  logic              r_full;
  logic              w_pop, w_flush_start, w_flush_end;
  logic              w_ack, w_tail_live, w_coalesce, w_push_ok;
  logic [TAG_W-1:0]  w_push_line;
  logic [PTR_W-1:0]  w_tail_ptr;
  logic              w_unused_bits;

  assign w_push_line   = inv_push_addr[29:SUB_LINE_W];
  assign w_unused_bits = ^inv_push_addr[SUB_LINE_W-1:0];
  assign w_tail_ptr    = r_wptr - PTR_W'(1);
  assign w_sweep_inc   = r_sweep + LINE_W'(1);
  assign w_ack         = tag_inv_ack & r_valid;

  // The tail may be merged only if it is still waiting: not the in-flight
  // head, and not an entry that the running sweep is about to subsume.
  assign w_tail_live = (r_count != '0)
                     && !((r_state == S_ISSUE) && (r_count == CNT_W'(1)))
                     && !((r_state == S_FLUSH) && (r_wptr == r_flush_wptr));
  assign w_coalesce  = w_tail_live && (r_mem[w_tail_ptr] == w_push_line);
  assign w_push_ok   = inv_push && (r_count != CNT_W'(DEPTH)) && !w_coalesce;

  // Next-state and next-output decode for the issue/flush sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_valid_nxt   = r_valid;
    w_addr_nxt    = r_addr;
    w_sweep_nxt   = r_sweep;
    w_pending_nxt = r_pending | flush_req;
    w_done_nxt    = 1'b0;
    w_pop         = 1'b0;
    w_flush_start = 1'b0;
    w_flush_end   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_state_nxt   = S_FLUSH;
          w_sweep_nxt   = '0;
          w_addr_nxt    = '0;
          w_valid_nxt   = !fetch_busy;
          w_pending_nxt = 1'b0;
          w_flush_start = 1'b1;
        end else if ((r_count != '0) && !fetch_busy) begin
          w_state_nxt = S_ISSUE;
          w_valid_nxt = 1'b1;
          w_addr_nxt  = {r_mem[r_rptr], {SUB_LINE_W{1'b0}}};
        end
      end
      S_ISSUE: begin
        // Once presented, the request stays up until the banks take it.
        if (w_ack) begin
          w_pop       = 1'b1;
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_FLUSH: begin
        w_pending_nxt = 1'b0;
        if (flush_req) begin
          w_sweep_nxt = '0;
          w_addr_nxt  = '0;
          w_valid_nxt = !fetch_busy || (r_valid && !w_ack);
        end else if (w_ack) begin
          if (r_sweep == LINE_W'(LINES - 1)) begin
            w_done_nxt  = 1'b1;
            w_valid_nxt = 1'b0;
            w_flush_end = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_sweep_nxt = w_sweep_inc;
            w_addr_nxt  = {{PAD_W{1'b0}}, w_sweep_inc, {SUB_LINE_W{1'b0}}};
            w_valid_nxt = !fetch_busy;
          end
        end else if (!r_valid) begin
          w_valid_nxt = !fetch_busy;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // Queue occupancy: entries present at sweep start are dropped at its end.
  always_comb begin
    if (w_flush_end)
      w_count_nxt = r_count - r_sub_cnt + CNT_W'(w_push_ok);
    else
      w_count_nxt = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
  end

  // Sequencer state and registered tag-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_sweep   <= '0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_valid_nxt;
      r_addr    <= w_addr_nxt;
      r_sweep   <= w_sweep_nxt;
      r_pending <= w_pending_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Queue pointers, count and the sweep-start snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_flush_wptr <= '0;
      r_sub_cnt    <= '0;
    end else begin
      if (w_push_ok)
        r_wptr <= r_wptr + PTR_W'(1);
      if (w_flush_end)
        r_rptr <= r_flush_wptr;
      else if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      if (w_flush_start) begin
        r_flush_wptr <= r_wptr;
        r_sub_cnt    <= r_count;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
    end
  end

  // Queue storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wptr] <= w_push_line;
  end

  assign inv_full      = r_full;
  assign tag_inv_valid = r_valid;
  assign tag_inv_addr  = r_addr;
  assign flush_busy    = r_pending | (r_state == S_FLUSH);
  assign flush_done    = r_done;
  assign queue_empty   = (r_count == '0) & !r_valid & !flush_busy;

endmodule
`default_nettype wire

// File: tb/tb_icache_inv_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_inv_scheduler
// Description : Directed bench for icache_inv_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_inv_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        inv_push;
  logic [29:0] inv_push_addr;
  logic        inv_full;
  logic        flush_req;
  logic        fetch_busy;
  logic        tag_inv_valid;
  logic [29:0] tag_inv_addr;
  logic        tag_inv_ack;
  logic        flush_busy;
  logic        flush_done;
  logic        queue_empty;
  logic        r_ack_man;
  logic        r_ack_auto;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign tag_inv_ack = r_ack_man | (r_ack_auto & tag_inv_valid);

  icache_inv_scheduler #(.DEPTH(4), .LINES(512), .SUB_LINE_W(3)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .inv_push      (inv_push),
    .inv_push_addr (inv_push_addr),
    .inv_full      (inv_full),
    .flush_req     (flush_req),
    .fetch_busy    (fetch_busy),
    .tag_inv_valid (tag_inv_valid),
    .tag_inv_addr  (tag_inv_addr),
    .tag_inv_ack   (tag_inv_ack),
    .flush_busy    (flush_busy),
    .flush_done    (flush_done),
    .queue_empty   (queue_empty)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [29:0] a);
    inv_push      = 1'b1;
    inv_push_addr = a;
    @(negedge clk);
    inv_push      = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, tag_inv_valid, 0);
    chk({tag, "_addr"},  tag_inv_addr,  0);
    chk({tag, "_full"},  inv_full,      0);
    chk({tag, "_busy"},  flush_busy,    0);
    chk({tag, "_done"},  flush_done,    0);
    chk({tag, "_empty"}, queue_empty,   1);
  endtask

  // Wait (bounded) for a request, check its address, ack it for one cycle.
  task automatic expect_issue(input string tag, input logic [29:0] exp);
    int n = 0;
    while (!tag_inv_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, tag_inv_valid, 1);
    chk({tag, "_addr"},  tag_inv_addr,  exp);
    r_ack_man = 1'b1;
    @(negedge clk);
    r_ack_man = 1'b0;
    chk({tag, "_drop"}, tag_inv_valid, 0);
  endtask

  // Follow a sweep with auto-ack; optionally push at one line or reset at one.
  task automatic run_sweep(input int push_at, input logic [29:0] paddr, input int rst_at,
                           output int nlines, output int nbad, output int ndone);
    nlines = 0;
    nbad   = 0;
    ndone  = 0;
    r_ack_auto = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      inv_push = 1'b0;
      if (flush_done) begin
        ndone++;
        r_ack_auto = 1'b0;
        break;
      end
      if (tag_inv_valid) begin
        if (nlines == rst_at) begin
          rst        = 1'b1;
          r_ack_auto = 1'b0;
          break;
        end
        if (tag_inv_addr !== 30'(nlines * 8)) nbad++;
        if (nlines == push_at) begin
          inv_push      = 1'b1;
          inv_push_addr = paddr;
        end
        nlines++;
      end
    end
    r_ack_auto = 1'b0;
  endtask

  initial begin
    int nl, nb, nd;
    rst = 1'b1; inv_push = 1'b0; inv_push_addr = '0; flush_req = 1'b0;
    fetch_busy = 1'b0; r_ack_man = 1'b0; r_ack_auto = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst");

    // Basic issue: request appears in the second cycle after the push.
    push(30'h0000_0104);
    chk("basic_early", tag_inv_valid, 0);
    @(negedge clk);
    expect_issue("basic", 30'h0000_0100);
    chk("basic_empty", queue_empty, 1);

    // Fill with fetch busy, coalesce a repeat of the tail line.
    fetch_busy = 1'b1;
    push(30'h0000_1000);
    push(30'h0000_2008);
    push(30'h0000_3010);
    push(30'h0000_4018);
    chk("fill_full", inv_full, 1);
    push(30'h0000_401C);
    chk("fill_full2", inv_full, 1);
    repeat (3) @(negedge clk);
    chk("fill_noissue", tag_inv_valid, 0);
    fetch_busy = 1'b0;
    expect_issue("fill_a", 30'h0000_1000);
    chk("fill_notfull", inv_full, 0);
    expect_issue("fill_b", 30'h0000_2008);
    expect_issue("fill_c", 30'h0000_3010);
    expect_issue("fill_d", 30'h0000_4018);
    repeat (3) @(negedge clk);
    chk("fill_no5th", tag_inv_valid, 0);
    chk("fill_empty", queue_empty, 1);

    // Coalescing below full: E, E(same line), F gives two issues.
    fetch_busy = 1'b1;
    push(30'h0000_5000);
    push(30'h0000_5004);
    push(30'h0000_6000);
    fetch_busy = 1'b0;
    expect_issue("coal_e", 30'h0000_5000);
    expect_issue("coal_f", 30'h0000_6000);
    repeat (3) @(negedge clk);
    chk("coal_idle", tag_inv_valid, 0);
    chk("coal_empty", queue_empty, 1);

    // Back-pressure: request held while fetch_busy toggles and ack is late.
    push(30'h0000_7000);
    @(negedge clk);
    chk("bp_valid", tag_inv_valid, 1);
    for (int i = 0; i < 5; i++) begin
      fetch_busy = ~fetch_busy;
      @(negedge clk);
      chk("bp_hold_valid", tag_inv_valid, 1);
      chk("bp_hold_addr", tag_inv_addr, 30'h0000_7000);
    end
    fetch_busy = 1'b0;
    expect_issue("bp", 30'h0000_7000);
    repeat (3) @(negedge clk);
    chk("bp_onepop", tag_inv_valid, 0);
    chk("bp_empty", queue_empty, 1);

    // Full flush with two queued entries that the sweep subsumes.
    fetch_busy = 1'b1;
    push(30'h0000_8000);
    push(30'h0000_9000);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    chk("fl_busy", flush_busy, 1);
    chk("fl_noempty", queue_empty, 0);
    fetch_busy = 1'b0;
    run_sweep(-1, '0, -1, nl, nb, nd);
    chk("fl_lines", nl, 512);
    chk("fl_order", nb, 0);
    chk("fl_done", nd, 1);
    chk("fl_idlebusy", flush_busy, 0);
    @(negedge clk);
    chk("fl_donepulse", flush_done, 0);
    repeat (3) @(negedge clk);
    chk("fl_subsumed", tag_inv_valid, 0);
    chk("fl_empty", queue_empty, 1);

    // Push during the sweep survives and issues next.
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    run_sweep(50, 30'h0000_A00C, -1, nl, nb, nd);
    chk("pd_lines", nl, 512);
    chk("pd_order", nb, 0);
    chk("pd_done", nd, 1);
    chk("pd_kept", queue_empty, 0);
    expect_issue("pd_x", 30'h0000_A008);
    repeat (2) @(negedge clk);
    chk("pd_empty", queue_empty, 1);

    // Reset at sweep line 100, then a fresh sweep starts from line 0.
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    run_sweep(-1, '0, 100, nl, nb, nd);
    chk("rs_reached", nl, 100);
    chk("rs_order", nb, 0);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rs");
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    run_sweep(-1, '0, -1, nl, nb, nd);
    chk("rs2_lines", nl, 512);
    chk("rs2_order", nb, 0);
    chk("rs2_done", nd, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
